// File: rtl/tinyalu_param.sv
// Parametrised tiny ALU: a command FIFO feeds an IDLE/EXEC/MUL engine.
// Results are 2*WIDTH bits wide, and an illegal opcode completes with err set.
module tinyalu_param #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [WIDTH-1:0]            A,
    input  logic [WIDTH-1:0]            B,
    input  logic [2:0]                  op,
    output logic                        cmd_ready,
    output logic                        done,
    output logic [2*WIDTH-1:0]          result,
    output logic                        err,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int MW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int EW = 2 * WIDTH + 3;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [MW-1:0] MUL_LOAD = MW'(MUL_CYCLES - 1);

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;

    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic [MW-1:0]    mul_cnt_r;
    logic             push_s;
    logic             pop_s;
    logic [EW-1:0]    head_s;

    assign cmd_ready = (fifo_count < DEPTH_C);
    assign push_s    = start && cmd_ready;
    assign pop_s     = (state_r == IDLE) && (fifo_count != {CW{1'b0}});
    assign head_s    = mem[rd_ptr_r];
    assign busy      = (state_r != IDLE) || (fifo_count != {CW{1'b0}});

    // Returns {err, result}; operands are zero-extended so sub borrows into the upper half.
    function automatic logic [2*WIDTH:0] alu(input logic [2:0] o,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ax;
        logic [2*WIDTH-1:0] bx;
        logic [2*WIDTH-1:0] r;
        logic               e;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        e  = 1'b0;
        case (o)
            OP_ADD:  r = ax + bx;
            OP_AND:  r = ax & bx;
            OP_XOR:  r = ax ^ bx;
            OP_MUL:  r = ax * bx;
            OP_SUB:  r = ax - bx;
            OP_OR:   r = ax | bx;
            OP_ILL:  begin r = {2*WIDTH{1'b0}}; e = 1'b1; end
            default: r = {2*WIDTH{1'b0}};
        endcase
        return {e, r};
    endfunction

    // FIFO storage write; contents need no reset since pointers/count gate reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wr_ptr_r] <= {op, A, B};
        end
    end

    // FIFO pointers/count and the execution FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_count <= {CW{1'b0}};
            state_r    <= IDLE;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            op_r       <= OP_NOP;
            mul_cnt_r  <= {MW{1'b0}};
            done       <= 1'b0;
            err        <= 1'b0;
            result     <= {2*WIDTH{1'b0}};
        end else begin
            done <= 1'b0;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        {op_r, a_r, b_r} <= head_s;
                        mul_cnt_r        <= MUL_LOAD;
                        case (head_s[EW-1 -: 3])
                            OP_MUL:  state_r <= MUL;
                            OP_NOP:  state_r <= IDLE;
                            default: state_r <= EXEC;
                        endcase
                    end
                end
                EXEC: begin
                    {err, result} <= alu(op_r, a_r, b_r);
                    done          <= 1'b1;
                    state_r       <= IDLE;
                end
                MUL: begin
                    if (mul_cnt_r == {MW{1'b0}}) begin
                        {err, result} <= alu(op_r, a_r, b_r);
                        done          <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        mul_cnt_r <= mul_cnt_r - MW'(1);
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tinyalu_param.sv
// Directed self-checking bench for tinyalu_param at WIDTH=8/MUL_CYCLES=3
// and WIDTH=16/MUL_CYCLES=1; inputs change on negedge, outputs sampled on negedge.
module tb_tinyalu_param;
    logic        clk = 1'b0;
    logic        reset;
    logic        start8, start16;
    logic [7:0]  A8, B8;
    logic [15:0] A16, B16;
    logic [2:0]  op8, op16;
    logic        rdy8, done8, err8, busy8;
    logic        rdy16, done16, err16, busy16;
    logic [15:0] res8;
    logic [31:0] res16;
    logic [2:0]  cnt8, cnt16;

    int n_checks = 0;
    int n_fail   = 0;

    tinyalu_param #(.WIDTH(8), .MUL_CYCLES(3), .FIFO_DEPTH(4)) u8 (
        .clk(clk), .reset(reset), .start(start8), .A(A8), .B(B8), .op(op8),
        .cmd_ready(rdy8), .done(done8), .result(res8), .err(err8),
        .busy(busy8), .fifo_count(cnt8)
    );

    tinyalu_param #(.WIDTH(16), .MUL_CYCLES(1), .FIFO_DEPTH(4)) u16 (
        .clk(clk), .reset(reset), .start(start16), .A(A16), .B(B16), .op(op16),
        .cmd_ready(rdy16), .done(done16), .result(res16), .err(err16),
        .busy(busy16), .fifo_count(cnt16)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one command into an idle DUT and check the exact done latency.
    task automatic run_op(input bit wide, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp_res,
                          input logic exp_err, input int lat, input string tag);
        logic        d;
        logic [31:0] r;
        logic        e;
        if (wide) begin
            start16 = 1'b1; A16 = a; B16 = b; op16 = o;
        end else begin
            start8 = 1'b1; A8 = a[7:0]; B8 = b[7:0]; op8 = o;
        end
        step();
        start8  = 1'b0;
        start16 = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            step();
            d = wide ? done16 : done8;
            r = wide ? res16 : {16'h0000, res8};
            e = wide ? err16 : err8;
            if (k < lat) begin
                check_eq({tag, "_early_done"}, {31'd0, d}, 32'd0);
            end else begin
                check_eq({tag, "_done"}, {31'd0, d}, 32'd1);
                check_eq({tag, "_result"}, r, exp_res);
                check_eq({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
            end
        end
        step();
        d = wide ? done16 : done8;
        r = wide ? res16 : {16'h0000, res8};
        check_eq({tag, "_pulse_end"}, {31'd0, d}, 32'd0);
        check_eq({tag, "_held"}, r, exp_res);
        check_eq({tag, "_busy_low"}, {31'd0, (wide ? busy16 : busy8)}, 32'd0);
    endtask

    initial begin
        logic [7:0]  ma [5];
        logic [7:0]  mb [5];
        logic [15:0] mexp [5];
        int          idx;
        int          ndone;

        reset = 1'b1;
        start8 = 1'b0; start16 = 1'b0;
        A8 = 8'h00; B8 = 8'h00; op8 = 3'b000;
        A16 = 16'h0000; B16 = 16'h0000; op16 = 3'b000;
        step();
        step();
        check_eq("rst_done", {31'd0, done8}, 32'd0);
        check_eq("rst_result", {16'h0000, res8}, 32'd0);
        check_eq("rst_ready", {31'd0, rdy8}, 32'd1);
        check_eq("rst_busy", {31'd0, busy8}, 32'd0);
        check_eq("rst16_ready", {31'd0, rdy16}, 32'd1);
        check_eq("rst16_count", {29'd0, cnt16}, 32'd0);
        check_eq("rst16_busy", {31'd0, busy16}, 32'd0);
        reset = 1'b0;

        // T1: reset mid-traffic
        start8 = 1'b1; op8 = 3'b100; A8 = 8'h12; B8 = 8'h34;
        step();
        op8 = 3'b001;
        step();
        start8 = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check_eq("t1_done", {31'd0, done8}, 32'd0);
        check_eq("t1_result", {16'h0000, res8}, 32'd0);
        check_eq("t1_err", {31'd0, err8}, 32'd0);
        check_eq("t1_ready", {31'd0, rdy8}, 32'd1);
        check_eq("t1_count", {29'd0, cnt8}, 32'd0);
        check_eq("t1_busy", {31'd0, busy8}, 32'd0);

        // T2/T3 at WIDTH=8, MUL_CYCLES=3
        run_op(1'b0, 3'b001, 16'h00FF, 16'h0001, 32'h0000_0100, 1'b0, 2, "add8");
        run_op(1'b0, 3'b101, 16'h0003, 16'h0005, 32'h0000_FFFE, 1'b0, 2, "sub8");
        run_op(1'b0, 3'b110, 16'h00F0, 16'h000F, 32'h0000_00FF, 1'b0, 2, "or8");
        run_op(1'b0, 3'b010, 16'h00F0, 16'h003C, 32'h0000_0030, 1'b0, 2, "and8");
        run_op(1'b0, 3'b011, 16'h00F0, 16'h003C, 32'h0000_00CC, 1'b0, 2, "xor8");
        run_op(1'b0, 3'b100, 16'h00FF, 16'h00FF, 32'h0000_FE01, 1'b0, 4, "mul8");

        // T4: five back-to-back multiplies
        ma[0] = 8'hFF; mb[0] = 8'hFF; mexp[0] = 16'hFE01;
        ma[1] = 8'h02; mb[1] = 8'h03; mexp[1] = 16'h0006;
        ma[2] = 8'h10; mb[2] = 8'h10; mexp[2] = 16'h0100;
        ma[3] = 8'h80; mb[3] = 8'h03; mexp[3] = 16'h0180;
        ma[4] = 8'h0F; mb[4] = 8'h0F; mexp[4] = 16'h00E1;
        for (int i = 0; i < 5; i++) begin
            start8 = 1'b1; op8 = 3'b100; A8 = ma[i]; B8 = mb[i];
            step();
        end
        start8 = 1'b0;
        check_eq("t4_count", {29'd0, cnt8}, 32'd4);
        check_eq("t4_ready", {31'd0, rdy8}, 32'd0);
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            if (done8) begin
                if (idx < 5) begin
                    check_eq("t4_product", {16'h0000, res8}, {16'h0000, mexp[idx]});
                    check_eq("t4_err", {31'd0, err8}, 32'd0);
                end
                idx++;
            end
            step();
        end
        check_eq("t4_num_done", idx, 32'd5);
        check_eq("t4_busy", {31'd0, busy8}, 32'd0);

        // T5: illegal opcode and no_op
        run_op(1'b0, 3'b111, 16'h0012, 16'h0034, 32'h0000_0000, 1'b1, 2, "ill8");
        start8 = 1'b1; op8 = 3'b000; A8 = 8'h55; B8 = 8'hAA;
        step();
        start8 = 1'b0;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (done8) ndone++;
        end
        check_eq("t5_nop_done", ndone, 32'd0);
        check_eq("t5_nop_count", {29'd0, cnt8}, 32'd0);
        check_eq("t5_nop_busy", {31'd0, busy8}, 32'd0);

        // T6: reset while multiplying with two queued
        for (int i = 0; i < 3; i++) begin
            start8 = 1'b1; op8 = 3'b100; A8 = ma[i]; B8 = mb[i];
            step();
        end
        start8 = 1'b0;
        check_eq("t6_queued", {29'd0, cnt8}, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("t6_count", {29'd0, cnt8}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (done8) ndone++;
        end
        check_eq("t6_no_done", ndone, 32'd0);
        check_eq("t6_busy", {31'd0, busy8}, 32'd0);

        // T2/T3 rerun at WIDTH=16, MUL_CYCLES=1
        run_op(1'b1, 3'b001, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 2, "add16");
        run_op(1'b1, 3'b101, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 1'b0, 2, "sub16");
        run_op(1'b1, 3'b110, 16'hF0F0, 16'h0F0F, 32'h0000_FFFF, 1'b0, 2, "or16");
        run_op(1'b1, 3'b100, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 2, "mul16");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
